// File: rtl/fifo_arbiter.sv
// fifo_arbiter: two-requester round-robin write arbiter plus single read port
// in front of a downstream FIFO. Tracks the committed FIFO occupancy, issues
// registered write/read strobes, drains the FIFO on a flush pulse and latches
// into an ERROR state on any FIFO status fault until reset.
module fifo_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_req,
  input  logic [DATA_W-1:0]          a_din,
  output logic                       a_gnt,
  input  logic                       b_req,
  input  logic [DATA_W-1:0]          b_din,
  output logic                       b_gnt,
  input  logic                       rd_req,
  output logic                       rd_gnt,
  input  logic                       flush,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_din,
  output logic                       fifo_rd_en,
  input  logic                       fifo_rd_ack,
  input  logic                       fifo_wr_err,
  input  logic                       fifo_rd_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic                last_b_q, last_b_d;   // 1: B was granted most recently
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_pend_q;            // a read strobe went out last cycle

  logic                drain_rd;
  logic                wr_fire;
  logic                rd_fire;
  logic                err_in;
  logic                has_room;
  logic                has_data;

  // Occupancy update clamped to [0, DEPTH]; a simultaneous write and read
  // leaves the count unchanged.
  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] cur,
                                               input logic          inc,
                                               input logic          dec);
    logic [CW-1:0] res;
    res = cur;
    if (inc && !dec) begin
      if (cur != DEPTH_C) res = cur + ONE_C;
    end else if (dec && !inc) begin
      if (cur != '0) res = cur - ONE_C;
    end
    return res;
  endfunction

  assign has_room = (count_q != DEPTH_C);
  assign has_data = (count_q != '0);

  // A missing read acknowledge one cycle after a read strobe counts as a fault.
  assign err_in = fifo_wr_err | fifo_rd_err | (rd_pend_q & ~fifo_rd_ack);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a fault overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave at the edge where the last entry is read, or after one idle
        // cycle when the flush arrived with the FIFO already empty.
        if (count_q <= ONE_C) state_d = ST_RUN;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
    if (err_in) state_d = ST_ERROR;
  end

  // FSM outputs: same-cycle grants in RUN and the internal drain read.
  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    rd_gnt   = 1'b0;
    drain_rd = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (!flush) begin
            if (has_room) begin
              if (a_req && b_req) begin
                a_gnt = last_b_q;
                b_gnt = ~last_b_q;
              end else begin
                a_gnt = a_req;
                b_gnt = b_req;
              end
            end
            rd_gnt = rd_req & has_data;
          end
        end
        ST_DRAIN: begin
          drain_rd = has_data;
        end
        default: begin
        end
      endcase
    end
  end

  assign wr_fire = a_gnt | b_gnt;
  assign rd_fire = rd_gnt | drain_rd;

  // Next values for occupancy, round-robin pointer and FIFO strobes; a fault
  // cycle commits nothing so ERROR is entered with no strobe pending.
  always_comb begin
    count_d  = count_q;
    last_b_d = last_b_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    din_d    = din_q;
    if (!err_in) begin
      count_d = sat_count(count_q, wr_fire, rd_fire);
      wr_en_d = wr_fire;
      rd_en_d = rd_fire;
      if (a_gnt) begin
        last_b_d = 1'b0;
        din_d    = a_din;
      end else if (b_gnt) begin
        last_b_d = 1'b1;
        din_d    = b_din;
      end
    end
  end

  // Control registers: occupancy, pointer and strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      last_b_q  <= 1'b1;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      last_b_q  <= last_b_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      rd_pend_q <= rd_en_q;
    end
  end

  // Write data register; cleared on reset so the port idles at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q <= '0;
    end else begin
      din_q <= din_d;
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign fifo_rd_en = rd_en_q;
  assign count      = count_q;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign err        = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: directed scenarios for fifo_arbiter with hand-computed
// expectations. The downstream FIFO is modelled only as far as returning
// fifo_rd_ack one cycle after each fifo_rd_en.
module tb_fifo_arbiter;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              a_req, b_req, rd_req, flush;
  logic [DATA_W-1:0] a_din, b_din;
  logic              a_gnt, b_gnt, rd_gnt;
  logic              fifo_wr_en, fifo_rd_en;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_rd_ack, fifo_wr_err, fifo_rd_err;
  logic [CW-1:0]     count;
  logic              full, empty, err;

  int checks;
  int failures;

  fifo_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_din(a_din), .a_gnt(a_gnt),
    .b_req(b_req), .b_din(b_din), .b_gnt(b_gnt),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .flush(flush),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_ack(fifo_rd_ack), .fifo_wr_err(fifo_wr_err), .fifo_rd_err(fifo_rd_err),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Well-behaved FIFO: acknowledge every read strobe one cycle later.
  always @(posedge clk) fifo_rd_ack <= reset ? 1'b0 : fifo_rd_en;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_req = 0; b_req = 0; rd_req = 0; flush = 0;
    fifo_wr_err = 0; fifo_rd_err = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    a_din = 32'hdead; b_din = 32'hbeef;
    reset = 1;
    a_req = 1;
    tick();
    tick();
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en: got %0b want 0", fifo_wr_en); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en: got %0b want 0", fifo_rd_en); end
    checks++; if (fifo_din !== '0) begin failures++; $display("FAIL rst_din: got %0h want 0", fifo_din); end
    checks++; if (count !== '0) begin failures++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if ({err, full, empty} !== 3'b001) begin failures++; $display("FAIL rst_flags: got err/full/empty=%b want 001", {err, full, empty}); end
    reset = 0;
    idle();
  endtask

  task automatic test_arbitration();
    logic exp_a;
    do_reset();
    a_req = 1; b_req = 1; a_din = 1; b_din = 2;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      checks++; if ({a_gnt, b_gnt} !== {exp_a, ~exp_a}) begin failures++; $display("FAIL arb_gnt[%0d]: got a/b=%b want %b", i, {a_gnt, b_gnt}, {exp_a, ~exp_a}); end
      tick();
      checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== (exp_a ? 32'd1 : 32'd2)) begin failures++; $display("FAIL arb_din[%0d]: got en=%0b din=%0d want en=1 din=%0d", i, fifo_wr_en, fifo_din, exp_a ? 1 : 2); end
    end
    idle();
    checks++; if (count !== CW'(4)) begin failures++; $display("FAIL arb_count: got %0d want 4", count); end
    tick();
    checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL arb_wr_idle: got %0b want 0", fifo_wr_en); end
  endtask

  task automatic test_single_pointer();
    do_reset();
    b_req = 1; b_din = 7;
    #1;
    checks++; if ({a_gnt, b_gnt} !== 2'b01) begin failures++; $display("FAIL single_b: got a/b=%b want 01", {a_gnt, b_gnt}); end
    tick();
    checks++; if (fifo_din !== 32'd7) begin failures++; $display("FAIL single_b_din: got %0d want 7", fifo_din); end
    a_req = 1; a_din = 5;
    #1;
    checks++; if ({a_gnt, b_gnt} !== 2'b10) begin failures++; $display("FAIL rr_after_b: got a/b=%b want 10", {a_gnt, b_gnt}); end
    tick();
    #1;
    checks++; if ({a_gnt, b_gnt} !== 2'b01) begin failures++; $display("FAIL rr_after_a: got a/b=%b want 01", {a_gnt, b_gnt}); end
    tick();
    idle();
    checks++; if (count !== CW'(3)) begin failures++; $display("FAIL single_count: got %0d want 3", count); end
  endtask

  task automatic test_fill_full();
    logic exp_g;
    do_reset();
    a_req = 1;
    for (int i = 0; i < 10; i++) begin
      exp_g = (i < DEPTH);
      a_din = 100 + i;
      #1;
      checks++; if (a_gnt !== exp_g) begin failures++; $display("FAIL fill_gnt[%0d]: got %0b want %0b", i, a_gnt, exp_g); end
      checks++; if (full !== (i >= DEPTH)) begin failures++; $display("FAIL fill_full[%0d]: got %0b want %0b", i, full, i >= DEPTH); end
      tick();
      checks++; if (fifo_wr_en !== exp_g) begin failures++; $display("FAIL fill_wr_en[%0d]: got %0b want %0b", i, fifo_wr_en, exp_g); end
    end
    idle();
    checks++; if (count !== CW'(DEPTH) || full !== 1'b1 || empty !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL fill_end: got count=%0d full=%0b empty=%0b err=%0b want 8 1 0 0", count, full, empty, err); end
  endtask

  task automatic test_read_full();
    a_req = 1; a_din = 55; rd_req = 1;
    #1;
    checks++; if ({rd_gnt, a_gnt} !== 2'b10) begin failures++; $display("FAIL rdfull_gnt: got rd/a=%b want 10", {rd_gnt, a_gnt}); end
    tick();
    checks++; if (count !== CW'(7) || fifo_rd_en !== 1'b1 || fifo_wr_en !== 1'b0) begin failures++; $display("FAIL rdfull_after: got count=%0d rd_en=%0b wr_en=%0b want 7 1 0", count, fifo_rd_en, fifo_wr_en); end
    #1;
    checks++; if ({rd_gnt, a_gnt} !== 2'b11) begin failures++; $display("FAIL rdwr_gnt: got rd/a=%b want 11", {rd_gnt, a_gnt}); end
    tick();
    checks++; if (count !== CW'(7) || fifo_rd_en !== 1'b1 || fifo_wr_en !== 1'b1 || fifo_din !== 32'd55) begin failures++; $display("FAIL rdwr_after: got count=%0d rd_en=%0b wr_en=%0b din=%0d want 7 1 1 55", count, fifo_rd_en, fifo_wr_en, fifo_din); end
    idle();
  endtask

  task automatic test_flush();
    rd_req = 1;
    tick();
    tick();
    rd_req = 0;
    checks++; if (count !== CW'(5)) begin failures++; $display("FAIL flush_pre_count: got %0d want 5", count); end
    flush = 1; a_req = 1; a_din = 77; rd_req = 1;
    #1;
    checks++; if ({a_gnt, rd_gnt} !== 2'b00) begin failures++; $display("FAIL flush_cycle_gnt: got a/rd=%b want 00", {a_gnt, rd_gnt}); end
    tick();
    flush = 0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++; if ({a_gnt, b_gnt, rd_gnt} !== 3'b000) begin failures++; $display("FAIL drain_gnt[%0d]: got a/b/rd=%b want 000", k, {a_gnt, b_gnt, rd_gnt}); end
      tick();
      checks++; if (fifo_rd_en !== 1'b1 || count !== CW'(5 - k)) begin failures++; $display("FAIL drain_rd[%0d]: got rd_en=%0b count=%0d want 1 %0d", k, fifo_rd_en, count, 5 - k); end
    end
    #1;
    checks++; if ({a_gnt, rd_gnt, err} !== 3'b100) begin failures++; $display("FAIL drain_back_run: got a/rd/err=%b want 100", {a_gnt, rd_gnt, err}); end
    tick();
    checks++; if (fifo_rd_en !== 1'b0 || fifo_wr_en !== 1'b1 || count !== CW'(1)) begin failures++; $display("FAIL drain_done: got rd_en=%0b wr_en=%0b count=%0d want 0 1 1", fifo_rd_en, fifo_wr_en, count); end
    idle();
  endtask

  task automatic test_empty_read();
    do_reset();
    rd_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rd_gnt !== 1'b0) begin failures++; $display("FAIL empty_rd_gnt[%0d]: got %0b want 0", i, rd_gnt); end
      tick();
      checks++; if (fifo_rd_en !== 1'b0 || count !== '0) begin failures++; $display("FAIL empty_rd_en[%0d]: got rd_en=%0b count=%0d want 0 0", i, fifo_rd_en, count); end
    end
    idle();
  endtask

  task automatic test_error();
    do_reset();
    a_req = 1; a_din = 3;
    tick();
    tick();
    fifo_wr_err = 1;
    tick();
    fifo_wr_err = 0;
    checks++; if (err !== 1'b1 || fifo_wr_en !== 1'b0 || count !== CW'(2)) begin failures++; $display("FAIL err_entry: got err=%0b wr_en=%0b count=%0d want 1 0 2", err, fifo_wr_en, count); end
    a_req = 1; b_req = 1; rd_req = 1;
    for (int i = 0; i < 6; i++) begin
      flush = (i == 2);
      #1;
      checks++; if ({a_gnt, b_gnt, rd_gnt} !== 3'b000) begin failures++; $display("FAIL err_gnt[%0d]: got a/b/rd=%b want 000", i, {a_gnt, b_gnt, rd_gnt}); end
      tick();
      checks++; if ({err, fifo_wr_en, fifo_rd_en} !== 3'b100) begin failures++; $display("FAIL err_hold[%0d]: got err/wr/rd=%b want 100", i, {err, fifo_wr_en, fifo_rd_en}); end
    end
    idle();
    reset = 1;
    tick();
    checks++; if (err !== 1'b0 || count !== '0 || empty !== 1'b1) begin failures++; $display("FAIL err_reset: got err=%0b count=%0d empty=%0b want 0 0 1", err, count, empty); end
    reset = 0;
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    a_req = 1; a_din = 4;
    tick(); tick(); tick();
    a_req = 0;
    flush = 1;
    tick();
    flush = 0;
    tick();
    checks++; if (fifo_rd_en !== 1'b1 || count !== CW'(2)) begin failures++; $display("FAIL rdr_drain: got rd_en=%0b count=%0d want 1 2", fifo_rd_en, count); end
    reset = 1;
    tick();
    checks++; if ({fifo_rd_en, fifo_wr_en, err} !== 3'b000 || count !== '0) begin failures++; $display("FAIL rdr_reset: got rd/wr/err=%b count=%0d want 000 0", {fifo_rd_en, fifo_wr_en, err}, count); end
    reset = 0;
    a_req = 1; a_din = 9;
    #1;
    checks++; if (a_gnt !== 1'b1) begin failures++; $display("FAIL rdr_release_gnt: got %0b want 1", a_gnt); end
    tick();
    checks++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'd9 || err !== 1'b0) begin failures++; $display("FAIL rdr_release_wr: got wr_en=%0b din=%0d err=%0b want 1 9 0", fifo_wr_en, fifo_din, err); end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1;
    a_din = '0; b_din = '0;
    idle();
    test_reset();
    test_arbitration();
    test_single_pointer();
    test_fill_full();
    test_read_full();
    test_flush();
    test_empty_read();
    test_error();
    test_reset_in_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of data words on all data ports.
REQ-002 Parameter DEPTH, default 8, SHALL set the entry count of the downstream FIFO being arbitrated.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 a_req  input  1  SHALL carry requester A's write request.
REQ-006 a_din  input  DATA_W  SHALL carry requester A's write data.
REQ-007 a_gnt  output  1  SHALL be requester A's write accept, combinational, same cycle.
REQ-008 b_req  input  1  SHALL carry requester B's write request.
REQ-009 b_din  input  DATA_W  SHALL carry requester B's write data.
REQ-010 b_gnt  output  1  SHALL be requester B's write accept, combinational, same cycle.
REQ-011 rd_req  input  1  SHALL carry the consumer read request.
REQ-012 rd_gnt  output  1  SHALL be the consumer read accept, combinational, same cycle.
REQ-013 flush  input  1  SHALL be a single-cycle pulse requesting a drain of the FIFO.
REQ-014 fifo_wr_en  output  1  SHALL be the registered FIFO write strobe.
REQ-015 fifo_din  output  DATA_W  SHALL be the registered FIFO write data.
REQ-016 fifo_rd_en  output  1  SHALL be the registered FIFO read strobe.
REQ-017 fifo_rd_ack, fifo_wr_err, fifo_rd_err  input  1 each  SHALL be the FIFO status returns.
REQ-018 count  output  $clog2(DEPTH)+1  SHALL report the committed occupancy.
REQ-019 full, empty  output  1 each  SHALL be decoded as count==DEPTH and count==0.
REQ-020 err  output  1  SHALL be high whenever the FSM is in state ERROR.

Function
REQ-021 The FSM SHALL have the states RUN, DRAIN and ERROR.
REQ-022 In RUN, a write SHALL be granted only when count<DEPTH, with at most one write granted per cycle.
REQ-023 Round-robin: with a_req and b_req both high, the requester not granted last SHALL win; after reset A SHALL win first.
REQ-024 With a single requester active, that requester SHALL be granted whenever REQ-022 allows, and the last-grant pointer SHALL update to it.
REQ-025 On a write grant in cycle N, fifo_wr_en=1 and fifo_din=granted data SHALL appear in cycle N+1 for exactly one cycle.
REQ-026 rd_gnt SHALL assert only when rd_req=1, the state is RUN and count>0.
REQ-027 On a read grant in cycle N, fifo_rd_en=1 SHALL appear in cycle N+1 for exactly one cycle.
REQ-028 count SHALL update at the end of a grant cycle by +1 for a write, -1 for a read, and 0 when both are granted together.
REQ-029 Simultaneous read and write grants SHALL be allowed at count 0 < count < DEPTH.
REQ-030 No write SHALL be granted at full and no read at empty.
REQ-031 At full with rd_req=1, only the read SHALL be granted that cycle.
REQ-032 count SHALL never wrap below 0 or above DEPTH.
REQ-033 A flush pulse in RUN SHALL cause RUN->DRAIN at the next edge, with all grants low that cycle.
REQ-034 In DRAIN, a read SHALL be issued internally every cycle (fifo_rd_en=1, count-1) while count>0, with a_gnt, b_gnt and rd_gnt held low.
REQ-035 DRAIN->RUN SHALL occur at the edge where count reaches 0; a flush with count==0 SHALL give one DRAIN cycle, then RUN.
REQ-036 fifo_wr_err=1 or fifo_rd_err=1 in any state SHALL cause a transition to ERROR at the next edge.
REQ-037 In ERROR, all grants, fifo_wr_en and fifo_rd_en SHALL be 0, and the state SHALL hold until reset.
REQ-038 fifo_rd_ack SHALL be monitored only: if it is not high in the cycle after a fifo_rd_en, the block SHALL enter ERROR.
REQ-039 A flush arriving in DRAIN or ERROR SHALL be ignored.

Reset
REQ-040 While reset=1 at an edge, the state SHALL become RUN and count 0.
REQ-041 While reset=1 at an edge, the outputs SHALL become fifo_wr_en=0, fifo_rd_en=0, fifo_din=0, err=0, full=0 and empty=1.
REQ-042 While reset=1 at an edge, the round-robin pointer SHALL favour A.
REQ-043 Reset mid-operation, including in DRAIN or ERROR, SHALL take effect at the next edge and discard any pending strobes.
REQ-044 In the cycle after reset is released, the grant outputs SHALL follow the same-cycle requests as specified in Function.

Verification
REQ-045 The bench SHALL cover arbitration: a_req=b_req=1 for 4 cycles from reset, a_din=1, b_din=2 -> grants A,B,A,B; fifo_din 1,2,1,2 one cycle later; count=4.
REQ-046 The bench SHALL cover fill to full: a_req held for 10 cycles -> 8 grants, full=1 at count 8, a_gnt=0 for the last 2 cycles, no fifo_wr_err.
REQ-047 The bench SHALL cover read at full: count=8, rd_req=1, a_req=1 -> rd_gnt=1, a_gnt=0, count=7; the next cycle both grant and count stays 7.
REQ-048 The bench SHALL cover flush: count=5, flush pulse -> DRAIN, exactly 5 consecutive fifo_rd_en, then count=0, RUN, requests granted again.
REQ-049 The bench SHALL cover error: fifo_wr_err pulsed once -> err=1 the next cycle, all grants 0 for 5+ cycles; reset -> err=0, count=0.
REQ-050 The bench SHALL cover empty read: count=0, rd_req=1 -> rd_gnt=0, fifo_rd_en never asserted.
